// File: rtl/cardinal_nic_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cardinal_nic_if                                            |
// | Description : Processor register bus and router PE-port signals of the   |
// |               cardinal NIC, bundled for use as a single module port.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface cardinal_nic_if #(
   parameter int DATA_W = 64
);
   // processor side
   logic [1:0]        addr;
   logic [DATA_W-1:0] d_in;
   logic [DATA_W-1:0] d_out;
   logic              nicEn;
   logic              nicWrEn;
   // router side
   logic              net_so;
   logic              net_ro;
   logic [DATA_W-1:0] net_do;
   logic              net_si;
   logic              net_ri;
   logic [DATA_W-1:0] net_di;
   logic              net_polarity;

   // environment: processor plus router
   modport master (
      output addr, d_in, nicEn, nicWrEn, net_ro, net_si, net_di, net_polarity,
      input  d_out, net_so, net_do, net_ri
   );

   // the NIC itself
   modport slave (
      input  addr, d_in, nicEn, nicWrEn, net_ro, net_si, net_di, net_polarity,
      output d_out, net_so, net_do, net_ri
   );
endinterface
`default_nettype wire

// File: rtl/cardinal_nic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cardinal_nic                                               |
// | Description : Network interface between a processor and the PE port of   |
// |               one mesh router. Four memory-mapped registers: in_buf,     |
// |               in_status, out_buf, out_status. Egress is gated on router  |
// |               polarity versus packet VC bit (bit DATA_W-1).              |
// | Option      : CARDINAL_NIC_OUT_FIFO_EN replaces the single egress buffer |
// |               with an OUT_DEPTH-entry FIFO (out_status bit1 = empty).    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cardinal_nic #(
   parameter int DATA_W    = 64,
   parameter int OUT_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   cardinal_nic_if.slave bus
);
   localparam int VC = DATA_W - 1;

   logic              rd_en;
   logic              wr_en;
   logic              out_wr;
   logic              inject;
   logic              in_full;
   logic [DATA_W-1:0] in_buf;
   logic [DATA_W-1:0] d_out_q;
   logic              out_full;
   logic              out_empty_flag;

   assign rd_en      = bus.nicEn & ~bus.nicWrEn;
   assign wr_en      = bus.nicEn & bus.nicWrEn;
   // a write is judged against the pre-edge full flag, so a write colliding
   // with the injection of a full buffer is dropped
   assign out_wr     = wr_en & (bus.addr == 2'd2) & ~out_full;
   assign bus.net_ri = ~in_full;
   assign bus.net_so = inject;
   assign bus.d_out  = d_out_q;

`ifdef CARDINAL_NIC_OUT_FIFO_EN
   localparam int PTR_W = $clog2(OUT_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] fifo_mem [OUT_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;

   assign out_full       = (count == CNT_W'(OUT_DEPTH));
   assign out_empty_flag = (count == '0);
   assign bus.net_do     = fifo_mem[rd_ptr];
   assign inject         = ~out_empty_flag & bus.net_ro &
                           (fifo_mem[rd_ptr][VC] != bus.net_polarity);

   // egress FIFO: power-of-two depth lets the pointers wrap naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         if (out_wr) begin
            fifo_mem[wr_ptr] <= bus.d_in;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (inject) rd_ptr <= rd_ptr + PTR_W'(1);
         if (out_wr && !inject)      count <= count + CNT_W'(1);
         else if (inject && !out_wr) count <= count - CNT_W'(1);
      end
   end
`else
   logic [DATA_W-1:0] out_buf;
   logic              unused_depth;

   // depth only matters for the FIFO build
   assign unused_depth   = (OUT_DEPTH > 1);
   assign out_empty_flag = 1'b0;
   assign bus.net_do     = out_buf;
   assign inject         = out_full & bus.net_ro & (out_buf[VC] != bus.net_polarity);

   // single-entry egress buffer; out_buf keeps its contents after injection
   always_ff @(posedge clk) begin
      if (reset) begin
         out_full <= 1'b0;
         out_buf  <= '0;
      end else if (inject) begin
         out_full <= 1'b0;
      end else if (out_wr) begin
         out_buf  <= bus.d_in;
         out_full <= 1'b1;
      end
   end
`endif

   // ingress capture and read-clear; the two never coincide since net_ri=0
   // whenever in_full=1
   always_ff @(posedge clk) begin
      if (reset) begin
         in_full <= 1'b0;
         in_buf  <= '0;
      end else if (bus.net_si && !in_full) begin
         in_buf  <= bus.net_di;
         in_full <= 1'b1;
      end else if (rd_en && (bus.addr == 2'd0) && in_full) begin
         in_full <= 1'b0;
      end
   end

   // registered read data, held when there is no read access
   always_ff @(posedge clk) begin
      if (reset) begin
         d_out_q <= '0;
      end else if (rd_en) begin
         case (bus.addr)
            2'd0:    d_out_q <= in_buf;
            2'd1:    d_out_q <= DATA_W'(in_full);
            2'd2:    d_out_q <= '0;
            default: d_out_q <= DATA_W'({out_empty_flag, out_full});
         endcase
      end
   end
endmodule
`default_nettype wire
